// File: rtl/power_enable_sequencer.sv
// Power-enable sequencer for a conv -> pool -> fc pipeline.
// Each stage's enable rises a few cycles (WAKE_CYCLES) before its start pulse so the
// downstream clock gating unit can settle. The enable is held HOLD_CYCLES after the
// stage completes. Optional activity counters are built only when the macro
// PWR_ACT_STATS_EN is defined; otherwise the act_* ports are tied to zero.
module power_enable_sequencer #(
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        conv_done,
    input  logic        pool_done,
    input  logic        fc_done,
    output logic        en_conv,
    output logic        en_pool,
    output logic        en_fc,
    output logic        conv_start,
    output logic        pool_start,
    output logic        fc_start,
    output logic        busy,
    output logic        seq_done,
    output logic [31:0] act_conv,
    output logic [31:0] act_pool,
    output logic [31:0] act_fc
);

    typedef enum logic [2:0] {
        StIdle, StConvWake, StConvRun, StPoolWake, StPoolRun, StFcWake, StFcRun, StDone
    } state_e;

    localparam logic [3:0] WakeLast = 4'(WAKE_CYCLES - 1);
    localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES);

    state_e          state_q, state_d;
    logic [3:0]      wake_q, wake_d;
    logic [2:0][3:0] hold_q, hold_d;
    logic [2:0]      leave;       // stage i leaves its RUN state this cycle
    logic [2:0]      en_q, en_d;  // index 0 conv, 1 pool, 2 fc
    logic [2:0]      go_q, go_d;  // registered start pulses

    // Next-state, wake/hold counters and registered output targets.
    always_comb begin
        state_d = state_q;
        wake_d  = wake_q;
        hold_d  = hold_q;
        leave   = 3'b000;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StConvWake;
                    wake_d  = 4'd0;
                end
            end
            StConvWake, StPoolWake, StFcWake: begin
                if (wake_q == WakeLast) begin
                    state_d = (state_q == StConvWake) ? StConvRun :
                              (state_q == StPoolWake) ? StPoolRun : StFcRun;
                end else begin
                    wake_d = wake_q + 4'd1;
                end
            end
            StConvRun: begin
                if (conv_done) begin
                    state_d  = StPoolWake;
                    wake_d   = 4'd0;
                    leave[0] = 1'b1;
                end
            end
            StPoolRun: begin
                if (pool_done) begin
                    state_d  = StFcWake;
                    wake_d   = 4'd0;
                    leave[1] = 1'b1;
                end
            end
            StFcRun: begin
                if (fc_done) begin
                    state_d  = StDone;
                    leave[2] = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Hold counters run independently so they can overlap later stages.
        for (int i = 0; i < 3; i++) begin
            if (leave[i]) begin
                hold_d[i] = HoldInit;
            end else if (hold_q[i] != 4'd0) begin
                hold_d[i] = hold_q[i] - 4'd1;
            end
        end

        // Abort wins over start and every done input.
        if (abort) begin
            state_d = StIdle;
            hold_d  = '0;
        end

        en_d[0] = (state_d == StConvWake) || (state_d == StConvRun) || (hold_d[0] != 4'd0);
        en_d[1] = (state_d == StPoolWake) || (state_d == StPoolRun) || (hold_d[1] != 4'd0);
        en_d[2] = (state_d == StFcWake)   || (state_d == StFcRun)   || (hold_d[2] != 4'd0);

        go_d[0] = (state_d == StConvRun) && (state_q != StConvRun);
        go_d[1] = (state_d == StPoolRun) && (state_q != StPoolRun);
        go_d[2] = (state_d == StFcRun)   && (state_q != StFcRun);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            wake_q  <= 4'd0;
            hold_q  <= '0;
            en_q    <= 3'b000;
            go_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            wake_q  <= wake_d;
            hold_q  <= hold_d;
            en_q    <= en_d;
            go_q    <= go_d;
        end
    end

    assign en_conv    = en_q[0];
    assign en_pool    = en_q[1];
    assign en_fc      = en_q[2];
    assign conv_start = go_q[0];
    assign pool_start = go_q[1];
    assign fc_start   = go_q[2];
    assign busy       = (state_q != StIdle);
    assign seq_done   = (state_q == StDone);

`ifdef PWR_ACT_STATS_EN
    logic [2:0][31:0] act_q, act_d;
    logic             clr;

    assign clr = (state_q == StIdle) && start && !abort;

    // Saturating per-stage enable-active counters, cleared on an accepted start.
    always_comb begin
        act_d = act_q;
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                act_d[i] = 32'd0;
            end else if (en_q[i] && (act_q[i] != 32'hFFFF_FFFF)) begin
                act_d[i] = act_q[i] + 32'd1;
            end
        end
    end

    // Activity counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q <= '0;
        end else begin
            act_q <= act_d;
        end
    end

    assign act_conv = act_q[0];
    assign act_pool = act_q[1];
    assign act_fc   = act_q[2];
`else
    assign act_conv = 32'd0;
    assign act_pool = 32'd0;
    assign act_fc   = 32'd0;
`endif

endmodule

// File: tb/tb_power_enable_sequencer.sv
// Bench for power_enable_sequencer: a default instance (WAKE=2, HOLD=4) and a HOLD=0
// instance share one set of inputs. Start pulses and seq_done of the default instance
// are checked by a scoreboard monitor; enable/busy levels are checked cycle by cycle.
module tb_power_enable_sequencer;

`ifdef PWR_ACT_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic conv_done = 1'b0, pool_done = 1'b0, fc_done = 1'b0;

    logic en_conv, en_pool, en_fc, conv_start, pool_start, fc_start, busy, seq_done;
    logic [31:0] act_conv, act_pool, act_fc;
    logic h_en_conv, h_en_pool, h_en_fc, h_conv_start, h_pool_start, h_fc_start;
    logic h_busy, h_seq_done;
    logic [31:0] h_act_conv, h_act_pool, h_act_fc;

    power_enable_sequencer u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .conv_done(conv_done), .pool_done(pool_done), .fc_done(fc_done),
        .en_conv(en_conv), .en_pool(en_pool), .en_fc(en_fc),
        .conv_start(conv_start), .pool_start(pool_start), .fc_start(fc_start),
        .busy(busy), .seq_done(seq_done),
        .act_conv(act_conv), .act_pool(act_pool), .act_fc(act_fc)
    );

    power_enable_sequencer #(.WAKE_CYCLES(2), .HOLD_CYCLES(0)) u_dut_h0 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .conv_done(conv_done), .pool_done(pool_done), .fc_done(fc_done),
        .en_conv(h_en_conv), .en_pool(h_en_pool), .en_fc(h_en_fc),
        .conv_start(h_conv_start), .pool_start(h_pool_start), .fc_start(h_fc_start),
        .busy(h_busy), .seq_done(h_seq_done),
        .act_conv(h_act_conv), .act_pool(h_act_pool), .act_fc(h_act_fc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int kind;  // 0 conv_start, 1 pool_start, 2 fc_start, 3 seq_done
        int at;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every pulse must match the next expected event and cycle.
    logic [3:0] mon_p;
    ev_t        mon_e;
    always @(negedge clk) begin
        mon_p = {seq_done, fc_start, pool_start, conv_start};
        for (int k = 0; k < 4; k++) begin
            if (mon_p[k]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: kind %0d at cyc %0d, none expected", k, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_kind", k, mon_e.kind);
                    chk($sformatf("pulse_cycle_kind%0d", k), cyc, mon_e.at);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, {29'd0, en_fc, en_pool, en_conv}, 32'd0);
        chk({tag, "_starts"}, {29'd0, fc_start, pool_start, conv_start}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_seq_done"}, {31'd0, seq_done}, 32'd0);
        chk({tag, "_act_conv"}, act_conv, 32'd0);
        chk({tag, "_act_pool"}, act_pool, 32'd0);
        chk({tag, "_act_fc"}, act_fc, 32'd0);
        chk({tag, "_h0_en_busy"}, {28'd0, h_busy, h_en_fc, h_en_pool, h_en_conv}, 32'd0);
    endtask

    function automatic logic in_rng(input int o, input int lo, input int hi);
        return (o >= lo) && (o <= hi);
    endfunction

    // Full sequence: start@0, stray pool_done@5, conv_done@10, stray fc_done@15,
    // pool_done@20, ignored start@24, fc_done@25. Called with the DUT idle and quiet.
    task automatic run_nominal(input string tag);
        int s;
        s = cyc;
        exp_q.push_back('{kind: 0, at: s + 3});
        exp_q.push_back('{kind: 1, at: s + 13});
        exp_q.push_back('{kind: 2, at: s + 23});
        exp_q.push_back('{kind: 3, at: s + 26});
        for (int o = 0; o <= 31; o++) begin
            chk($sformatf("%s_en_conv@%0d", tag, o), {31'd0, en_conv}, {31'd0, in_rng(o, 1, 14)});
            chk($sformatf("%s_en_pool@%0d", tag, o), {31'd0, en_pool}, {31'd0, in_rng(o, 11, 24)});
            chk($sformatf("%s_en_fc@%0d", tag, o), {31'd0, en_fc}, {31'd0, in_rng(o, 21, 29)});
            chk($sformatf("%s_busy@%0d", tag, o), {31'd0, busy}, {31'd0, in_rng(o, 1, 26)});
            chk($sformatf("%s_h0_en_conv@%0d", tag, o), {31'd0, h_en_conv},
                {31'd0, in_rng(o, 1, 10)});
            chk($sformatf("%s_h0_en_fc@%0d", tag, o), {31'd0, h_en_fc},
                {31'd0, in_rng(o, 21, 25)});
            chk($sformatf("%s_h0_seq_done@%0d", tag, o), {31'd0, h_seq_done},
                {31'd0, (o == 26)});
            chk($sformatf("%s_h0_busy@%0d", tag, o), {31'd0, h_busy}, {31'd0, in_rng(o, 1, 26)});
            start     = (o == 0) || (o == 24);
            conv_done = (o == 10);
            pool_done = (o == 5) || (o == 20);
            fc_done   = (o == 15) || (o == 25);
            @(negedge clk);
        end
        chk({tag, "_act_conv"}, act_conv, Stats ? 32'd14 : 32'd0);
        chk({tag, "_act_pool"}, act_pool, Stats ? 32'd14 : 32'd0);
        chk({tag, "_act_fc"}, act_fc, Stats ? 32'd9 : 32'd0);
        chk({tag, "_h0_act_conv"}, h_act_conv, Stats ? 32'd10 : 32'd0);
        chk({tag, "_h0_act_fc"}, h_act_fc, Stats ? 32'd5 : 32'd0);
    endtask

    // Abort in POOL_RUN while en_conv is still holding; start and pool_done collide
    // with the abort and must lose.
    task automatic run_abort();
        int s;
        s = cyc;
        exp_q.push_back('{kind: 0, at: s + 3});
        exp_q.push_back('{kind: 1, at: s + 6});
        for (int o = 0; o <= 11; o++) begin
            chk($sformatf("ab_en_conv@%0d", o), {31'd0, en_conv}, {31'd0, in_rng(o, 1, 7)});
            chk($sformatf("ab_en_pool@%0d", o), {31'd0, en_pool}, {31'd0, in_rng(o, 4, 7)});
            chk($sformatf("ab_en_fc@%0d", o), {31'd0, en_fc}, 32'd0);
            chk($sformatf("ab_busy@%0d", o), {31'd0, busy}, {31'd0, in_rng(o, 1, 7)});
            chk($sformatf("ab_h0_en_conv@%0d", o), {31'd0, h_en_conv}, {31'd0, in_rng(o, 1, 3)});
            start     = (o == 0) || (o == 7);
            conv_done = (o == 3);
            pool_done = (o == 7);
            abort     = (o == 7);
            @(negedge clk);
        end
        chk("ab_act_conv", act_conv, Stats ? 32'd7 : 32'd0);
        chk("ab_act_pool", act_pool, Stats ? 32'd4 : 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("post_reset");

        run_nominal("nom1");
        run_nominal("nom2");
        run_abort();

        // Reset asserted mid-CONV_RUN must clear outputs without a clock edge.
        begin
            int s;
            s = cyc;
            exp_q.push_back('{kind: 0, at: s + 3});
            for (int o = 0; o <= 4; o++) begin
                chk($sformatf("rst_en_conv@%0d", o), {31'd0, en_conv}, {31'd0, in_rng(o, 1, 4)});
                start = (o == 0);
                @(negedge clk);
            end
            chk("rst_pre_busy", {31'd0, busy}, 32'd1);
            #2 reset_n = 1'b0;
            #1 chk_all_zero("async_reset");
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
        end
        run_nominal("after_rst");

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/power_enable_sequencer.md
POWER_ENABLE_SEQUENCER -- requirements
Module: power_enable_sequencer

Interface
REQ-001 SHALL provide parameter WAKE_CYCLES, default 2, meaning cycles an enable is high before the matching stage start pulse (legal 1..15).
REQ-002 SHALL provide parameter HOLD_CYCLES, default 4, meaning cycles an enable stays high after the stage's done (legal 0..15).
REQ-003 SHALL provide clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL provide reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide start  input  1  launches a conv->pool->fc sequence when sampled high.
REQ-006 SHALL provide abort  input  1  terminates any sequence.
REQ-007 SHALL provide conv_done, pool_done, fc_done  input  1 each  stage completion pulses.
REQ-008 SHALL provide en_conv, en_pool, en_fc  output  1 each  registered enables for the downstream clock gating unit.
REQ-009 SHALL provide conv_start, pool_start, fc_start  output  1 each  single-cycle stage launch pulses.
REQ-010 SHALL provide busy  output  1  high in any state other than IDLE.
REQ-011 SHALL provide seq_done  output  1  single-cycle pulse on sequence completion.
REQ-012 SHALL provide act_conv, act_pool, act_fc  output  32 each  enable-active cycle counters.

Function
REQ-013 SHALL implement FSM states IDLE, CONV_WAKE, CONV_RUN, POOL_WAKE, POOL_RUN, FC_WAKE, FC_RUN, DONE.
REQ-014 SHALL move IDLE->CONV_WAKE on start; start in any other state is ignored.
REQ-015 SHALL remain in each X_WAKE exactly WAKE_CYCLES cycles, then enter X_RUN.
REQ-016 SHALL assert x_start for exactly the first cycle of X_RUN.
REQ-017 SHALL leave X_RUN on the cycle after x_done is sampled high, to the next WAKE state (FC_RUN->DONE); x_done may arrive on the x_start cycle.
REQ-018 SHALL ignore any x_done not sampled in its own X_RUN state.
REQ-019 SHALL assert seq_done for the single DONE cycle, then return to IDLE.
REQ-020 SHALL drive en_x high from entry into X_WAKE through X_RUN, then for exactly HOLD_CYCLES further cycles after leaving X_RUN (per-stage 4-bit hold counter).
REQ-021 SHALL let hold periods overlap the next stage's WAKE/RUN; en_x drops the cycle after its hold counter reaches zero.
REQ-022 SHALL, on abort sampled high in any state, enter IDLE next cycle, clear all hold counters, and drive all en_x and x_start low that cycle; seq_done SHALL NOT pulse.
REQ-023 SHALL give abort priority over start and any x_done in the same cycle.
REQ-024 SHALL accept start in IDLE while prior holds are still counting; holds continue unaffected except en_conv, which is re-asserted by CONV_WAKE.

Reset
REQ-025 SHALL, while reset_n is low, force state IDLE, hold counters 0, all en_x, x_start, busy, seq_done 0, and act_x counters 0.
REQ-026 SHALL resume operation on the first rising clk edge after reset_n deasserts, regardless of mid-sequence assertion.

Configuration
REQ-027 SHALL, when PWR_ACT_STATS_EN is defined, increment act_x by 1 each cycle en_x is high, clear all act_x on an accepted start, and saturate at 32'hFFFF_FFFF.
REQ-028 SHALL, when PWR_ACT_STATS_EN is undefined, keep act_x ports present and tied to 0 with no counter logic.

Verification
REQ-029 SHALL cover nominal: WAKE=2, HOLD=4, start at cycle 0, conv_done at cycle 10 -> en_conv high cycles 1-14, conv_start at cycle 3, en_pool high from cycle 11, pool_start at cycle 13.
REQ-030 SHALL cover HOLD=0: fc_done at cycle N -> en_fc low at N+1, seq_done at N+1, busy low at N+2.
REQ-031 SHALL cover abort during POOL_RUN with en_conv still holding -> next cycle all en_x=0, busy=0, no seq_done.
REQ-032 SHALL cover stray pool_done in CONV_RUN and start during FC_RUN -> no state change, no extra pulses.
REQ-033 SHALL cover reset_n low mid-CONV_RUN -> outputs 0 immediately without a clock edge; a fresh start after release runs the full sequence.
REQ-034 SHALL cover PWR_ACT_STATS_EN defined -> after the REQ-029 sequence act_conv=14; undefined -> act_conv=0.
